// File: rtl/hk_spi_arb_if.sv
// Bundle between the housekeeping requesters, the arbiter
// and the shared ADC SPI master.
interface hk_spi_arb_if #(
  parameter int NR = 2
);
  logic [NR-1:0]    req_i;
  logic [NR*16-1:0] wr_h_i;
  logic [NR*16-1:0] wr_l_i;
  logic [NR-1:0]    gnt_o;
  logic [NR-1:0]    done_o;
  logic             err_o;
  logic [15:0]      rd_dat_o;
  logic             spi_start_o;
  logic [15:0]      spi_wr_h_o;
  logic [15:0]      spi_wr_l_o;
  logic             spi_bsy_i;
  logic [15:0]      spi_rd_l_i;

  modport slave (
    input  req_i,
    input  wr_h_i,
    input  wr_l_i,
    input  spi_bsy_i,
    input  spi_rd_l_i,
    output gnt_o,
    output done_o,
    output err_o,
    output rd_dat_o,
    output spi_start_o,
    output spi_wr_h_o,
    output spi_wr_l_o
  );

  modport master (
    output req_i,
    output wr_h_i,
    output wr_l_i,
    output spi_bsy_i,
    output spi_rd_l_i,
    input  gnt_o,
    input  done_o,
    input  err_o,
    input  rd_dat_o,
    input  spi_start_o,
    input  spi_wr_h_o,
    input  spi_wr_l_o
  );
endinterface

// File: rtl/hk_spi_arb.sv
// Round-robin arbiter/sequencer sharing one housekeeping
// ADC SPI master between NR requesters.
module hk_spi_arb #(
  parameter int NR      = 2,
  parameter int BSY_TMO = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  hk_spi_arb_if.slave   bus
);

  localparam int PW = (NR > 1) ? $clog2(NR) : 1;
  localparam int CW = $clog2(BSY_TMO) + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BSY,
    RUN,
    FIN
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  win_q, win_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NR-1:0]  gnt_q, gnt_d;
  logic           err_q, err_d;
  logic [15:0]    rd_q, rd_d;
  logic [15:0]    wh_q, wh_d;
  logic [15:0]    wl_q, wl_d;

  logic           found;
  logic [PW-1:0]  pick;
  int             j;

  // First requester at or after the pointer, wrapping at NR.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    j     = 0;
    for (int i = 0; i < NR; i++) begin
      j = (int'(ptr_q) + i) % NR;
      if (!found && bus.req_i[j]) begin
        found = 1'b1;
        pick  = PW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    err_d   = err_q;
    rd_d    = rd_q;
    wh_d    = wh_q;
    wl_d    = wl_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = pick;
          gnt_d   = NR'(1) << pick;
          wh_d    = bus.wr_h_i[int'(pick)*16 +: 16];
          wl_d    = bus.wr_l_i[int'(pick)*16 +: 16];
          err_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BSY;
      end
      WAIT_BSY: begin
        if (bus.spi_bsy_i) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // counter lands on BSY_TMO-1 with the move to FIN
          if (cnt_q == CW'(BSY_TMO - 2)) begin
            err_d   = 1'b1;
            state_d = FIN;
          end
        end
      end
      RUN: begin
        if (!bus.spi_bsy_i) state_d = FIN;
      end
      FIN: begin
        if (!err_q) rd_d = bus.spi_rd_l_i;
        gnt_d   = '0;
        ptr_d   = (win_q == PW'(NR - 1)) ?
                  '0 : win_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      err_q   <= 1'b0;
      rd_q    <= '0;
      wh_q    <= '0;
      wl_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wh_q    <= wh_d;
      wl_q    <= wl_d;
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.done_o      = (state_q == FIN) ? gnt_q : '0;
  assign bus.err_o       = (state_q == FIN) && err_q;
  assign bus.rd_dat_o    = rd_q;
  assign bus.spi_start_o = (state_q == START);
  assign bus.spi_wr_h_o  = wh_q;
  assign bus.spi_wr_l_o  = wl_q;

endmodule

// File: tb/tb_hk_spi_arb.sv
// Directed bench for hk_spi_arb (NR=2, BSY_TMO=16) with a
// simple SPI-master busy responder.
module tb_hk_spi_arb;

  logic clk;
  logic rst;

  hk_spi_arb_if #(.NR(2)) bus();

  hk_spi_arb #(
    .NR(2),
    .BSY_TMO(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  int ncmp = 0;
  int nerr = 0;
  int nstart = 0;
  int dly = 3;
  int len = 40;
  logic never = 1'b0;
  logic [15:0] rd_val = 16'h00A5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    ncmp++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic wait_start(input string t);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.spi_start_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({t, "_start_seen"}, 32'(seen), 1);
  endtask

  task automatic wait_done(input string t,
                           input logic [1:0] eg,
                           input logic [15:0] ewh,
                           output int n);
    logic seen;
    logic hold;
    seen = 1'b0;
    hold = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (bus.gnt_o !== eg || bus.spi_wr_h_o !== ewh)
        hold = 1'b0;
      if (bus.done_o !== 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
    chk({t, "_done_seen"}, 32'(seen), 1);
    chk({t, "_gnt_wh_hold"}, 32'(hold), 1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (bus.spi_start_o === 1'b1) nstart++;
    end
  end

  // SPI master model: busy rises dly cycles after start.
  initial begin
    bus.spi_bsy_i  = 1'b0;
    bus.spi_rd_l_i = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.spi_start_o === 1'b1 && !never) begin
        repeat (dly) @(posedge clk);
        #1 bus.spi_bsy_i = 1'b1;
        repeat (len) @(posedge clk);
        #1;
        bus.spi_bsy_i  = 1'b0;
        bus.spi_rd_l_i = rd_val;
      end
    end
  end

  initial begin
    int n;
    int s0;
    logic seen;
    logic [1:0]  eg  [4];
    logic [15:0] ewh [4];
    logic [15:0] ewl [4];
    eg  = '{2'b01, 2'b10, 2'b01, 2'b10};
    ewh = '{16'h8A00, 16'h8B01, 16'h8A00, 16'h8B01};
    ewl = '{16'hA0A0, 16'hB1B1, 16'hA0A0, 16'hB1B1};

    rst = 1'b1;
    bus.req_i  = 2'b00;
    bus.wr_h_i = {16'h4321, 16'h8012};
    bus.wr_l_i = {16'h5555, 16'h0000};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt_o), 0);
    chk("rst_done", 32'(bus.done_o), 0);
    chk("rst_err", 32'(bus.err_o), 0);
    chk("rst_start", 32'(bus.spi_start_o), 0);
    chk("rst_rd", 32'(bus.rd_dat_o), 0);
    chk("rst_wh", 32'(bus.spi_wr_h_o), 0);
    chk("rst_wl", 32'(bus.spi_wr_l_o), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // single request, long busy, wr_h changed after grant
    @(posedge clk);
    #1 bus.req_i = 2'b01;
    @(negedge clk);
    chk("t1_idle_start", 32'(bus.spi_start_o), 0);
    chk("t1_idle_gnt", 32'(bus.gnt_o), 0);
    @(negedge clk);
    chk("t1_start", 32'(bus.spi_start_o), 1);
    chk("t1_gnt", 32'(bus.gnt_o), 32'h1);
    chk("t1_wh", 32'(bus.spi_wr_h_o), 32'h8012);
    chk("t1_wl", 32'(bus.spi_wr_l_o), 32'h0000);
    @(negedge clk);
    bus.wr_h_i[15:0] = 16'h1234;
    wait_done("t1", 2'b01, 16'h8012, n);
    chk("t1_latency", n + 1, 44);
    chk("t1_done", 32'(bus.done_o), 32'h1);
    chk("t1_err", 32'(bus.err_o), 0);
    chk("t1_wh_fin", 32'(bus.spi_wr_h_o), 32'h8012);
    bus.req_i = 2'b00;
    @(negedge clk);
    chk("t1_rd", 32'(bus.rd_dat_o), 32'h00A5);
    chk("t1_gnt_clr", 32'(bus.gnt_o), 0);
    chk("t1_done_clr", 32'(bus.done_o), 0);

    // busy never rises
    never = 1'b1;
    bus.wr_h_i = {16'h4321, 16'h0055};
    @(posedge clk);
    #1 bus.req_i = 2'b01;
    wait_start("tmo");
    wait_done("tmo", 2'b01, 16'h0055, n);
    chk("tmo_cycles", n, 16);
    chk("tmo_done", 32'(bus.done_o), 32'h1);
    chk("tmo_err", 32'(bus.err_o), 1);
    bus.req_i = 2'b00;
    @(negedge clk);
    chk("tmo_rd_hold", 32'(bus.rd_dat_o), 32'h00A5);
    chk("tmo_err_clr", 32'(bus.err_o), 0);
    never = 1'b0;

    // normal transaction after timeout
    dly = 1;
    len = 5;
    rd_val = 16'h1111;
    bus.wr_h_i = {16'h8B01, 16'h8A00};
    bus.wr_l_i = {16'hB1B1, 16'hA0A0};
    @(posedge clk);
    #1 bus.req_i = 2'b10;
    wait_start("rec");
    chk("rec_gnt", 32'(bus.gnt_o), 32'h2);
    wait_done("rec", 2'b10, 16'h8B01, n);
    chk("rec_done", 32'(bus.done_o), 32'h2);
    chk("rec_err", 32'(bus.err_o), 0);
    bus.req_i = 2'b00;
    @(negedge clk);
    chk("rec_rd", 32'(bus.rd_dat_o), 32'h1111);

    // both requesting continuously
    rd_val = 16'h2222;
    s0 = nstart;
    @(posedge clk);
    #1 bus.req_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_start("rr");
      chk($sformatf("rr%0d_gnt", i), 32'(bus.gnt_o), 32'(eg[i]));
      chk($sformatf("rr%0d_wh", i), 32'(bus.spi_wr_h_o), 32'(ewh[i]));
      chk($sformatf("rr%0d_wl", i), 32'(bus.spi_wr_l_o), 32'(ewl[i]));
      wait_done("rr", eg[i], ewh[i], n);
      chk($sformatf("rr%0d_done", i), 32'(bus.done_o), 32'(eg[i]));
      chk($sformatf("rr%0d_err", i), 32'(bus.err_o), 0);
      if (i == 3) bus.req_i = 2'b00;
    end
    @(negedge clk);
    chk("rr_starts", nstart - s0, 4);
    chk("rr_rd", 32'(bus.rd_dat_o), 32'h2222);

    // requester 1 drops req during RUN
    @(posedge clk);
    #1 bus.req_i = 2'b10;
    wait_start("drop");
    chk("drop_gnt", 32'(bus.gnt_o), 32'h2);
    repeat (3) @(negedge clk);
    bus.req_i = 2'b00;
    wait_done("drop", 2'b10, 16'h8B01, n);
    chk("drop_done", 32'(bus.done_o), 32'h2);
    chk("drop_err", 32'(bus.err_o), 0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.gnt_o !== 2'b00) seen = 1'b1;
    end
    chk("drop_no_regrant", 32'(seen), 0);

    // move pointer to 1, then reset during RUN of requester 1
    @(posedge clk);
    #1 bus.req_i = 2'b01;
    wait_start("pre");
    wait_done("pre", 2'b01, 16'h8A00, n);
    bus.req_i = 2'b00;
    @(posedge clk);
    #1 bus.req_i = 2'b10;
    wait_start("mid");
    chk("mid_gnt", 32'(bus.gnt_o), 32'h2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.req_i = 2'b00;
    #1;
    chk("mrst_gnt", 32'(bus.gnt_o), 0);
    chk("mrst_start", 32'(bus.spi_start_o), 0);
    chk("mrst_rd", 32'(bus.rd_dat_o), 0);
    chk("mrst_wh", 32'(bus.spi_wr_h_o), 0);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done_o !== 2'b00) seen = 1'b1;
    end
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.done_o !== 2'b00) seen = 1'b1;
      if (bus.spi_bsy_i === 1'b0) break;
    end
    chk("mrst_no_done", 32'(seen), 0);
    chk("mrst_bsy_low", 32'(bus.spi_bsy_i), 0);
    @(posedge clk);
    #1 bus.req_i = 2'b11;
    wait_start("post");
    chk("post_gnt_ptr0", 32'(bus.gnt_o), 32'h1);
    chk("post_wh", 32'(bus.spi_wr_h_o), 32'h8A00);
    wait_done("post", 2'b01, 16'h8A00, n);
    chk("post_done", 32'(bus.done_o), 32'h1);
    bus.req_i = 2'b00;
    @(negedge clk);
    chk("post_rd", 32'(bus.rd_dat_o), 32'h2222);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
